mm_stream_tx: RTL and testbench
===============================

Name: mm_stream_tx

Overview:
- Host-side counterpart of the streaming matrix-multiply engine.
- Holds operand matrices A and B, each up to 4x4, loaded over a simple write port.
- On start, streams A then B row-major over the in_data/col_end/row_end protocol, then captures the result stream (out_data/valid/change_row/is_legal) into a readable result buffer.
- Sits between the host/testbench and the multiply engine.

Parameters:
DIM_MAX, 4, maximum rows/cols of any matrix
DW, 8, operand element width (signed)
OW, 20, result element width (signed)
TIMEOUT, 64, cycles allowed in WAIT_RES without the first valid before abort

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_we  in  1  operand write strobe
cfg_sel  in  1  0 = matrix A, 1 = matrix B
cfg_addr  in  4  element index, row*4+col
cfg_wdata  in  DW  element value
a_rows, a_cols, b_rows, b_cols  in  3 each  dimensions, legal range 1..4
start  in  1  single-cycle start request
in_data  out  DW  streamed element to engine
col_end  out  1  high with last element of each row
row_end  out  1  high with last element of each matrix
busy  in  1  engine computing/outputting
valid  in  1  engine result element valid
change_row  in  1  high with last result element of a row
is_legal  in  1  engine dimension-legality flag
out_data  in  OW  engine result element
res_addr  in  4  result read index, row*4+col
res_data  out  OW  combinational read of result buffer
res_rows, res_cols  out  3 each  captured result dimensions
res_illegal  out  1  engine reported an illegal multiply
res_timeout  out  1  aborted on timeout
cfg_err  out  1  one-cycle pulse: start rejected
done  out  1  one-cycle pulse at run end
idle  out  1  high in IDLE

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset all outputs are 0 except idle=1; buffers and counters are cleared; state = IDLE.
- A reset mid-run aborts immediately. No done pulse is generated.
- cfg_we is honoured only in IDLE. A write in any other state is ignored.
- States: IDLE -> SEND_A -> SEND_B -> WAIT_RES -> COLLECT -> FIN -> IDLE.

IDLE:
- start with any dimension equal to 0 or greater than DIM_MAX: pulse cfg_err, stay in IDLE.
- Otherwise latch dimensions, clear the result buffer and flags, go to SEND_A.

SEND_A / SEND_B:
- One element per cycle, row-major. Stream outputs are registered.
- col_end is high on the last column of each row.
- row_end is high only on the final element, together with col_end.
- No gap between A and B: the first B element follows the final A element in the next cycle.
- A 1x1 matrix is a single beat with col_end=row_end=1.
- Outside these states, in_data, col_end and row_end are 0.

WAIT_RES:
- Wait for valid.
- A counter counts cycles in this state. When it reaches TIMEOUT: set res_timeout, go to FIN.

COLLECT:
- Each valid cycle writes out_data at (r,c), then increments c.
- change_row high: r increments and c resets to 0. change_row also advances the row on a 1-column result.
- valid with is_legal=0: set res_illegal, store nothing, go to FIN.
- The run ends on the first cycle with valid=0 after collection began, or when the count reaches a_rows*b_cols; go to FIN.
- res_rows/res_cols record the counted rows and max columns. Expected values are a_rows / b_cols.

FIN:
- Pulse done for one cycle, return to IDLE.
- Flags hold until the next accepted start.

Other rules:
- start while not in IDLE is ignored.
- busy is informational only and is not required for the state transitions.
- Result buffer indices saturate at 3: writes beyond a 4x4 result are dropped.

Decomposition:
- Shared package mm_pkg: DIM_MAX, DW, OW, state enum, index helper (row*4+col).
- Sub-module mm_stream_seq: row/col counter generating col_end/row_end for a given rows×cols. Instantiated once and reused for A and B by reloading its dimensions.

Test Plan:
- Load A=2x3 [1 2 3; 4 5 6], B=3x2 [7 8; 9 10; 11 12], start. Required: 6 A beats with col_end on beats 3 and 6, row_end on beat 6, then 6 B beats. Result reads [58 64; 139 154], res_rows=2, res_cols=2, single done.
- Load A=2x2, B=3x2, start. Required: engine returns one valid beat with is_legal=0; res_illegal=1, done pulses, no buffer writes.
- Load A=[-128] 1x1, B=[-128] 1x1. Required: a single beat with col_end=row_end=1 per matrix; res_data(0)=16384.
- Load 4x4 matrices of 127, start. Required: 32 continuous beats, all results 64516, res_rows=res_cols=4.
- Start with a_cols=0. Required: cfg_err pulses, state stays IDLE, stream outputs stay 0. Start with valid never asserted: res_timeout=1 after 64 cycles in WAIT_RES, done pulses.
- Assert rst during SEND_B. Required: all outputs zero and idle=1 immediately; no done; the next run succeeds normally.

Source files
------------

// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_pkg
// Description : Shared constants, state encoding and index helper for the
//               host-side streaming matrix-multiply transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_pkg;

    localparam int DIM_MAX   = 4;   // largest row/col count of any matrix
    localparam int DW        = 8;   // operand element width (signed)
    localparam int OW        = 20;  // result element width (signed)
    localparam int TIMEOUT   = 64;  // WAIT_RES cycles before abort
    localparam int BUF_DEPTH = 16;  // 4x4 storage per buffer

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_A   = 3'd1,
        ST_SEND_B   = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_COLLECT  = 3'd4,
        ST_FIN      = 3'd5
    } mm_state_t;

    // Flat buffer index: row*4 + col.
    function automatic logic [3:0] mm_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mm_stream_seq.sv
`default_nettype none
// ============================================================================
// Module      : mm_stream_seq
// Description : Row-major position counter for one streamed matrix. Reports
//               the current (row, col) and whether it is the last column /
//               last row of the matrix whose dimensions are presented on
//               i_rows / i_cols. Counters self-clear whenever i_adv is low,
//               so the same instance serves A and then B.
// Ports       : clk, rst        - clock, async active-high reset
//               i_adv           - a beat is emitted at the current position
//               i_rows, i_cols  - dimensions of the matrix being streamed
//               o_row, o_col    - current position
//               o_last_col      - current position is in the last column
//               o_last_row      - current position is in the last row
// Revision    : 1.0 - initial release
// ============================================================================
module mm_stream_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_adv,
    input  logic [2:0] i_rows,
    input  logic [2:0] i_cols,
    output logic [1:0] o_row,
    output logic [1:0] o_col,
    output logic       o_last_col,
    output logic       o_last_row
);

    logic [1:0] r_row;
    logic [1:0] r_col;

    assign o_row      = r_row;
    assign o_col      = r_col;
    assign o_last_col = ({1'b0, r_col} == (i_cols - 3'd1));
    assign o_last_row = ({1'b0, r_row} == (i_rows - 3'd1));

    // After the final element the counters wrap to (0,0) so the next
    // matrix starts immediately without an idle beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= 2'd0;
            r_col <= 2'd0;
        end else if (!i_adv) begin
            r_row <= 2'd0;
            r_col <= 2'd0;
        end else if (o_last_col) begin
            r_col <= 2'd0;
            r_row <= o_last_row ? 2'd0 : r_row + 2'd1;
        end else begin
            r_col <= r_col + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mm_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : mm_stream_tx
// Description : Host-side transmitter for the streaming matrix-multiply
//               engine. Holds operand matrices A and B (up to 4x4), streams
//               A then B row-major on start, then captures the engine result
//               stream into a readable 4x4 result buffer.
// Ports       : clk, rst                 - clock, async active-high reset
//               cfg_we/sel/addr/wdata    - operand write port (IDLE only)
//               a_rows..b_cols           - matrix dimensions (1..DIM_MAX)
//               start                    - run request
//               in_data/col_end/row_end  - registered operand stream
//               busy/valid/change_row/
//               is_legal/out_data        - engine result interface
//               res_addr/res_data        - result buffer read port
//               res_rows/res_cols        - captured result dimensions
//               res_illegal/res_timeout  - run status flags
//               cfg_err/done/idle        - control status
// Revision    : 1.0 - initial release
// ============================================================================
module mm_stream_tx #(
    parameter int DIM_MAX = mm_pkg::DIM_MAX,
    parameter int DW      = mm_pkg::DW,
    parameter int OW      = mm_pkg::OW,
    parameter int TIMEOUT = mm_pkg::TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic          cfg_sel,
    input  logic [3:0]    cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    input  logic [2:0]    a_rows,
    input  logic [2:0]    a_cols,
    input  logic [2:0]    b_rows,
    input  logic [2:0]    b_cols,
    input  logic          start,
    output logic [DW-1:0] in_data,
    output logic          col_end,
    output logic          row_end,
    input  logic          busy,
    input  logic          valid,
    input  logic          change_row,
    input  logic          is_legal,
    input  logic [OW-1:0] out_data,
    input  logic [3:0]    res_addr,
    output logic [OW-1:0] res_data,
    output logic [2:0]    res_rows,
    output logic [2:0]    res_cols,
    output logic          res_illegal,
    output logic          res_timeout,
    output logic          cfg_err,
    output logic          done,
    output logic          idle
);

    import mm_pkg::*;

    localparam int c_WAIT_W = $clog2(TIMEOUT) + 1;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    mm_state_t           r_state;
    mm_state_t           w_next;

    logic [DW-1:0]       r_mat_a [BUF_DEPTH];
    logic [DW-1:0]       r_mat_b [BUF_DEPTH];
    logic [OW-1:0]       r_res   [BUF_DEPTH];

    logic [2:0]          r_a_rows;
    logic [2:0]          r_a_cols;
    logic [2:0]          r_b_rows;
    logic [2:0]          r_b_cols;

    logic [DW-1:0]       r_in_data;
    logic                r_col_end;
    logic                r_row_end;

    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [2:0]          r_row_idx;   // saturates at 4 = out of buffer
    logic [2:0]          r_col_idx;
    logic [4:0]          r_count;
    logic [2:0]          r_res_rows;
    logic [2:0]          r_res_cols;
    logic                r_res_illegal;
    logic                r_res_timeout;
    logic                r_cfg_err;

    logic                w_done;
    logic                w_idle;
    logic                w_dims_bad;
    logic                w_accept;
    logic                w_reject;
    logic                w_cur_is_b;
    logic                w_emit;
    logic [2:0]          w_seq_rows;
    logic [2:0]          w_seq_cols;
    logic [1:0]          w_seq_row;
    logic [1:0]          w_seq_col;
    logic                w_last_col;
    logic                w_last_row;
    logic [3:0]          w_elem_idx;
    logic [DW-1:0]       w_elem;
    logic                w_take;
    logic [5:0]          w_target;
    logic                w_hit_target;
    logic                w_timeout_hit;
    logic [2:0]          w_row_cnt;
    logic [2:0]          w_col_cnt;
    logic                w_unused_busy;

    // busy is informational; transitions are driven by valid alone.
    assign w_unused_busy = busy;

    function automatic logic dim_bad(input logic [2:0] d);
        return (d == 3'd0) || (32'(d) > DIM_MAX);
    endfunction

    assign w_dims_bad = dim_bad(a_rows) || dim_bad(a_cols) ||
                        dim_bad(b_rows) || dim_bad(b_cols);
    assign w_accept   = (r_state == ST_IDLE) && start && !w_dims_bad;
    assign w_reject   = (r_state == ST_IDLE) && start &&  w_dims_bad;

    // ------------------------------------------------------------------
    // Stream generation. The output registers show the beat of the
    // current state, so the lookahead beat is computed one cycle early:
    // the accepting IDLE cycle produces A[0], and the SEND_A cycle that
    // shows A's final beat already produces B[0].
    // ------------------------------------------------------------------
    assign w_cur_is_b = (r_state == ST_SEND_B) || ((r_state == ST_SEND_A) && r_row_end);
    assign w_emit     = w_accept || (r_state == ST_SEND_A) ||
                        ((r_state == ST_SEND_B) && !r_row_end);

    always_comb begin
        w_seq_rows = r_a_rows;
        w_seq_cols = r_a_cols;
        if (w_accept) begin
            w_seq_rows = a_rows;
            w_seq_cols = a_cols;
        end else if (w_cur_is_b) begin
            w_seq_rows = r_b_rows;
            w_seq_cols = r_b_cols;
        end
    end

    mm_stream_seq u_seq (
        .clk        (clk),
        .rst        (rst),
        .i_adv      (w_emit),
        .i_rows     (w_seq_rows),
        .i_cols     (w_seq_cols),
        .o_row      (w_seq_row),
        .o_col      (w_seq_col),
        .o_last_col (w_last_col),
        .o_last_row (w_last_row)
    );

    assign w_elem_idx = mm_idx(w_seq_row, w_seq_col);
    assign w_elem     = w_cur_is_b ? r_mat_b[w_elem_idx] : r_mat_a[w_elem_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_data <= '0;
            r_col_end <= 1'b0;
            r_row_end <= 1'b0;
        end else begin
            r_in_data <= w_emit ? w_elem : '0;
            r_col_end <= w_emit && w_last_col;
            r_row_end <= w_emit && w_last_col && w_last_row;
        end
    end

    // ------------------------------------------------------------------
    // Result capture decode
    // ------------------------------------------------------------------
    assign w_take        = valid && ((r_state == ST_WAIT_RES) || (r_state == ST_COLLECT));
    assign w_target      = 6'(r_a_rows) * 6'(r_b_cols);
    assign w_hit_target  = (({1'b0, r_count} + 6'd1) == w_target);
    assign w_timeout_hit = (r_state == ST_WAIT_RES) && !valid &&
                           (r_wait_cnt == c_WAIT_W'(TIMEOUT - 1));
    assign w_row_cnt     = r_row_idx[2] ? 3'd4 : r_row_idx + 3'd1;
    assign w_col_cnt     = r_col_idx[2] ? 3'd4 : r_col_idx + 3'd1;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_idle = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idle = 1'b1;
                if (w_accept) begin
                    w_next = ST_SEND_A;
                end
            end
            ST_SEND_A: begin
                if (r_row_end) begin
                    w_next = ST_SEND_B;
                end
            end
            ST_SEND_B: begin
                if (r_row_end) begin
                    w_next = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (valid) begin
                    w_next = (!is_legal || w_hit_target) ? ST_FIN : ST_COLLECT;
                end else if (w_timeout_hit) begin
                    w_next = ST_FIN;
                end
            end
            ST_COLLECT: begin
                if (!valid || !is_legal || w_hit_target) begin
                    w_next = ST_FIN;
                end
            end
            ST_FIN: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand buffers and dimension latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mat_a[i] <= '0;
                r_mat_b[i] <= '0;
            end
        end else if (cfg_we && (r_state == ST_IDLE)) begin
            if (cfg_sel) begin
                r_mat_b[cfg_addr] <= cfg_wdata;
            end else begin
                r_mat_a[cfg_addr] <= cfg_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rows <= 3'd0;
            r_a_cols <= 3'd0;
            r_b_rows <= 3'd0;
            r_b_cols <= 3'd0;
        end else if (w_accept) begin
            r_a_rows <= a_rows;
            r_a_cols <= a_cols;
            r_b_rows <= b_rows;
            r_b_cols <= b_cols;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == ST_WAIT_RES) ? r_wait_cnt + 1'b1 : '0;
            r_cfg_err  <= w_reject;
        end
    end

    // ------------------------------------------------------------------
    // Result buffer and run flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_res[i] <= '0;
            end
            r_row_idx     <= 3'd0;
            r_col_idx     <= 3'd0;
            r_count       <= 5'd0;
            r_res_rows    <= 3'd0;
            r_res_cols    <= 3'd0;
            r_res_illegal <= 1'b0;
            r_res_timeout <= 1'b0;
        end else if (w_accept) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_res[i] <= '0;
            end
            r_row_idx     <= 3'd0;
            r_col_idx     <= 3'd0;
            r_count       <= 5'd0;
            r_res_rows    <= 3'd0;
            r_res_cols    <= 3'd0;
            r_res_illegal <= 1'b0;
            r_res_timeout <= 1'b0;
        end else begin
            if (w_timeout_hit) begin
                r_res_timeout <= 1'b1;
            end
            if (w_take && !is_legal) begin
                r_res_illegal <= 1'b1;
            end
            if (w_take && is_legal) begin
                // Elements beyond the 4x4 window are counted but dropped.
                if (!r_row_idx[2] && !r_col_idx[2]) begin
                    r_res[mm_idx(r_row_idx[1:0], r_col_idx[1:0])] <= out_data;
                end
                r_count <= r_count + 5'd1;
                if (w_row_cnt > r_res_rows) begin
                    r_res_rows <= w_row_cnt;
                end
                if (w_col_cnt > r_res_cols) begin
                    r_res_cols <= w_col_cnt;
                end
                if (change_row) begin
                    r_row_idx <= w_row_cnt;
                    r_col_idx <= 3'd0;
                end else begin
                    r_col_idx <= w_col_cnt;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_data     = r_in_data;
    assign col_end     = r_col_end;
    assign row_end     = r_row_end;
    assign res_data    = r_res[res_addr];
    assign res_rows    = r_res_rows;
    assign res_cols    = r_res_cols;
    assign res_illegal = r_res_illegal;
    assign res_timeout = r_res_timeout;
    assign cfg_err     = r_cfg_err;
    assign done        = w_done;
    assign idle        = w_idle;

endmodule
`default_nettype wire

// File: tb/tb_mm_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm_stream_tx
// Description : Self-checking bench for mm_stream_tx. Acts as host and as a
//               behavioural multiply engine; expected streams and products
//               come from plain matrix arithmetic on the bench's own copies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_stream_tx;

    localparam int DW = 8;
    localparam int OW = 20;

    typedef struct {
        int data;
        bit ce;
        bit re;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic          cfg_sel;
    logic [3:0]    cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic [2:0]    a_rows, a_cols, b_rows, b_cols;
    logic          start;
    logic [DW-1:0] in_data;
    logic          col_end, row_end;
    logic          busy, valid, change_row, is_legal;
    logic [OW-1:0] out_data;
    logic [3:0]    res_addr;
    logic [OW-1:0] res_data;
    logic [2:0]    res_rows, res_cols;
    logic          res_illegal, res_timeout, cfg_err, done, idle;

    int n_checks = 0;
    int n_errors = 0;
    int ma [4][4];
    int mb [4][4];

    mm_stream_tx #(.DIM_MAX(4), .DW(DW), .OW(OW), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
        .start(start),
        .in_data(in_data), .col_end(col_end), .row_end(row_end),
        .busy(busy), .valid(valid), .change_row(change_row), .is_legal(is_legal),
        .out_data(out_data),
        .res_addr(res_addr), .res_data(res_data),
        .res_rows(res_rows), .res_cols(res_cols),
        .res_illegal(res_illegal), .res_timeout(res_timeout),
        .cfg_err(cfg_err), .done(done), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic sel, input int r, input int c, input int v);
        if (sel) mb[r][c] = v; else ma[r][c] = v;
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 4'(r * 4 + c); cfg_wdata = DW'(v);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        res_addr = 4'd0;
        #1;
        check({tag, "_in_data"}, {24'b0, in_data}, 0);
        check({tag, "_col_end"}, {31'b0, col_end}, 0);
        check({tag, "_row_end"}, {31'b0, row_end}, 0);
        check({tag, "_done"},    {31'b0, done}, 0);
        check({tag, "_cfg_err"}, {31'b0, cfg_err}, 0);
        check({tag, "_timeout"}, {31'b0, res_timeout}, 0);
        check({tag, "_illegal"}, {31'b0, res_illegal}, 0);
        check({tag, "_rows"},    {29'b0, res_rows}, 0);
        check({tag, "_cols"},    {29'b0, res_cols}, 0);
        check({tag, "_res0"},    {12'b0, res_data}, 0);
        check({tag, "_idle"},    {31'b0, idle}, 1);
    endtask

    task automatic do_start(input int ar, input int ac, input int br, input int bc);
        a_rows = 3'(ar); a_cols = 3'(ac); b_rows = 3'(br); b_cols = 3'(bc);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Expected stream: A row-major then B row-major, no gaps.
    task automatic check_stream(input string tag, input int ar, input int ac, input int br, input int bc);
        beat_t q[$];
        for (int i = 0; i < ar; i++)
            for (int j = 0; j < ac; j++)
                q.push_back('{ma[i][j], (j == ac - 1), (i == ar - 1) && (j == ac - 1)});
        for (int i = 0; i < br; i++)
            for (int j = 0; j < bc; j++)
                q.push_back('{mb[i][j], (j == bc - 1), (i == br - 1) && (j == bc - 1)});
        foreach (q[n]) begin
            if (n == 2) start = 1'b1;   // must be ignored mid-stream
            check($sformatf("%s_beat%0d_data", tag, n), {24'b0, in_data}, q[n].data & 255);
            check($sformatf("%s_beat%0d_ce", tag, n), {31'b0, col_end}, {31'b0, q[n].ce});
            check($sformatf("%s_beat%0d_re", tag, n), {31'b0, row_end}, {31'b0, q[n].re});
            tick();
            start = 1'b0;
        end
        check({tag, "_post_data"}, {24'b0, in_data}, 0);
        check({tag, "_post_ce"}, {31'b0, col_end}, 0);
        check({tag, "_post_re"}, {31'b0, row_end}, 0);
    endtask

    function automatic int prod(input int i, input int j, input int ac);
        int s = 0;
        for (int k = 0; k < ac; k++) s += ma[i][k] * mb[k][j];
        return s;
    endfunction

    task automatic engine_ok(input int ar, input int ac, input int bc);
        for (int i = 0; i < ar; i++)
            for (int j = 0; j < bc; j++) begin
                valid = 1'b1; is_legal = 1'b1; busy = 1'b1;
                change_row = (j == bc - 1);
                out_data = OW'(prod(i, j, ac));
                tick();
            end
        valid = 1'b0; change_row = 1'b0; out_data = '0; busy = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check({tag, "_done_seen"}, {31'b0, done}, 1);
        tick();
        check({tag, "_done_single"}, {31'b0, done}, 0);
        check({tag, "_idle_after"}, {31'b0, idle}, 1);
    endtask

    task automatic check_results(input string tag, input int ar, input int ac, input int bc);
        for (int i = 0; i < ar; i++)
            for (int j = 0; j < bc; j++) begin
                res_addr = 4'(i * 4 + j);
                #1;
                check($sformatf("%s_res_%0d_%0d", tag, i, j), {12'b0, res_data},
                      32'(prod(i, j, ac)) & 32'h000F_FFFF);
            end
        check({tag, "_res_rows"}, {29'b0, res_rows}, 32'(ar));
        check({tag, "_res_cols"}, {29'b0, res_cols}, 32'(bc));
        check({tag, "_illegal"}, {31'b0, res_illegal}, 0);
        check({tag, "_timeout"}, {31'b0, res_timeout}, 0);
    endtask

    task automatic run_mult(input string tag, input int ar, input int ac, input int bc, input int dly);
        do_start(ar, ac, ac, bc);
        check_stream(tag, ar, ac, ac, bc);
        for (int d = 0; d < dly; d++) begin
            // operand writes outside IDLE must not land
            cfg_we = (d == 0); cfg_sel = 1'b0; cfg_addr = 4'd0; cfg_wdata = ~DW'(ma[0][0]);
            tick();
            cfg_we = 1'b0;
        end
        engine_ok(ar, ac, bc);
        wait_done(tag);
        check_results(tag, ar, ac, bc);
    endtask

    task automatic load_test1();
        for (int i = 0; i < 2; i++) for (int j = 0; j < 3; j++) wr(1'b0, i, j, i * 3 + j + 1);
        for (int i = 0; i < 3; i++) for (int j = 0; j < 2; j++) wr(1'b1, i, j, 7 + i * 2 + j);
    endtask

    initial begin
        int k;
        int ar, ac, bc;
        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        a_rows = '0; a_cols = '0; b_rows = '0; b_cols = '0; start = 1'b0;
        busy = 1'b0; valid = 1'b0; change_row = 1'b0; is_legal = 1'b0; out_data = '0;
        res_addr = '0;
        #12;
        check_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Rejected starts
        a_rows = 3'd2; a_cols = 3'd0; b_rows = 3'd2; b_cols = 3'd2; start = 1'b1;
        tick();
        check("cfg_err_col0", {31'b0, cfg_err}, 1);
        check("cfg_err_col0_idle", {31'b0, idle}, 1);
        check("cfg_err_col0_data", {24'b0, in_data}, 0);
        a_cols = 3'd2; a_rows = 3'd5;
        tick();
        check("cfg_err_row5", {31'b0, cfg_err}, 1);
        start = 1'b0;
        tick();
        check("cfg_err_clear", {31'b0, cfg_err}, 0);
        check("cfg_err_stays_idle", {31'b0, idle}, 1);
        check("cfg_err_ce", {31'b0, col_end}, 0);

        // 2x3 * 3x2, then rerun without reload
        load_test1();
        run_mult("t1", 2, 3, 2, 3);
        run_mult("t1b", 2, 3, 2, 1);

        // Illegal dimensions reported by the engine
        for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) wr(1'b0, i, j, i + j + 1);
        do_start(2, 2, 3, 2);
        check_stream("ill", 2, 2, 3, 2);
        tick(); tick();
        valid = 1'b1; is_legal = 1'b0; out_data = 20'd12345;
        tick();
        valid = 1'b0; out_data = '0;
        wait_done("ill");
        check("ill_flag", {31'b0, res_illegal}, 1);
        check("ill_timeout", {31'b0, res_timeout}, 0);
        check("ill_rows", {29'b0, res_rows}, 0);
        for (int a = 0; a < 16; a++) begin
            res_addr = 4'(a);
            #1;
            check($sformatf("ill_nowrite_%0d", a), {12'b0, res_data}, 0);
        end

        // 1x1 of -128
        wr(1'b0, 0, 0, -128);
        wr(1'b1, 0, 0, -128);
        run_mult("one", 1, 1, 1, 0);

        // 4x4 of 127
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
            wr(1'b0, i, j, 127);
            wr(1'b1, i, j, 127);
        end
        run_mult("full", 4, 4, 4, 2);

        // Timeout: engine never answers
        wr(1'b0, 0, 0, 3);
        wr(1'b1, 0, 0, 5);
        do_start(1, 1, 1, 1);
        check_stream("tmo", 1, 1, 1, 1);
        k = 0;
        while (done !== 1'b1 && k < 200) begin
            if (k == 32) check("tmo_early_flag", {31'b0, res_timeout}, 0);
            tick();
            k++;
        end
        check("tmo_length_ok", {31'b0, (k >= 64 && k <= 65)}, 1);
        check("tmo_done", {31'b0, done}, 1);
        check("tmo_flag", {31'b0, res_timeout}, 1);
        check("tmo_illegal", {31'b0, res_illegal}, 0);
        tick();
        check("tmo_done_single", {31'b0, done}, 0);
        check("tmo_flag_holds", {31'b0, res_timeout}, 1);

        // Randomized runs
        for (int t = 0; t < 3; t++) begin
            ar = int'($urandom_range(1, 4));
            ac = int'($urandom_range(1, 4));
            bc = int'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
                wr(1'b0, i, j, int'($urandom_range(0, 255)) - 128);
                wr(1'b1, i, j, int'($urandom_range(0, 255)) - 128);
            end
            run_mult($sformatf("rnd%0d", t), ar, ac, bc, int'($urandom_range(1, 5)));
        end

        // Reset during SEND_B, then a normal run
        load_test1();
        do_start(2, 3, 3, 2);
        for (int n = 0; n < 7; n++) tick();   // showing second B beat
        check("pre_rst_idle", {31'b0, idle}, 0);
        rst = 1'b1;
        check_quiet("midrst");
        tick();
        check("midrst_no_done1", {31'b0, done}, 0);
        tick();
        check("midrst_no_done2", {31'b0, done}, 0);
        rst = 1'b0;
        tick();
        check("midrst_no_done3", {31'b0, done}, 0);
        load_test1();
        run_mult("after_rst", 2, 3, 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
